// File: rtl/comma_align_ctrl.sv
// Comma word aligner: masked plus/minus comma search over all 10 bit offsets with hunt/verify/lock offset selection.
// Define COMMA_ALIGN_STATS_EN to add o_RealignCnt, a saturating count of LOCKED->HUNT transitions.
module comma_align_ctrl #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [9:0]  i_RawData,
    input  logic        i_RawVld,
    input  logic [9:0]  i_Mask,
    input  logic [9:0]  i_PComma,
    input  logic [9:0]  i_MComma,
    input  logic        i_PComAlignEn,
    input  logic        i_MComAlignEn,
    input  logic        i_AlignEn,
    input  logic        i_Resync,
    output logic [9:0]  o_AlignData,
    output logic        o_AlignVld,
    output logic        o_ComDet,
    output logic [3:0]  o_Offset,
`ifdef COMMA_ALIGN_STATS_EN
    output logic        o_Locked,
    output logic [15:0] o_RealignCnt
`else
    output logic        o_Locked
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] LOCK_THR = 5'(LOCK_CNT);
    localparam logic [4:0] LOSS_THR = 5'(LOSS_CNT);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic comma_hit(input logic [9:0] cand, input logic [9:0] mask,
                                       input logic [9:0] pat, input logic en);
        return en && ((cand & mask) == (pat & mask));
    endfunction

    logic [9:0]  r_Prev;
    state_t      r_State;
    state_t      w_NextState;
    logic [3:0]  r_Offset;
    logic [3:0]  w_NextOffset;
    logic [3:0]  r_Cnt;
    logic [3:0]  w_NextCnt;
    logic [3:0]  r_ErrCnt;
    logic [3:0]  w_NextErr;
    logic [9:0]  r_AlignData_p1;
    logic        r_AlignVld_p1;
    logic        r_ComDet_p1;
    logic        r_Locked_p1;

    logic [19:0] w_Window;
    logic [9:0]  w_Cand [16];
    logic [15:0] w_Match;
    logic [3:0]  w_FirstHit;
    logic        w_AnyMatch;
    logic        w_MatchAtOff;
    logic        w_Advance;

    // p0: sliding window and comma compare at every offset; unused slots 10..15 stay zero
    assign w_Window = {i_RawData, r_Prev};

    always_comb begin
        w_Match = '0;
        for (int k = 0; k < 16; k++) begin
            w_Cand[k] = '0;
        end
        for (int k = 0; k < 10; k++) begin
            w_Cand[k]  = w_Window[k +: 10];
            w_Match[k] = comma_hit(w_Window[k +: 10], i_Mask, i_PComma, i_PComAlignEn)
                       | comma_hit(w_Window[k +: 10], i_Mask, i_MComma, i_MComAlignEn);
        end
    end

    always_comb begin
        w_FirstHit = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (w_Match[k]) begin
                w_FirstHit = 4'(k);
            end
        end
    end

    assign w_AnyMatch   = |w_Match;
    assign w_MatchAtOff = w_Match[r_Offset];
    assign w_Advance    = i_RawVld & i_AlignEn;

    always_comb begin
        w_NextState  = r_State;
        w_NextOffset = r_Offset;
        w_NextCnt    = r_Cnt;
        w_NextErr    = r_ErrCnt;
        if (i_Resync) begin
            w_NextState = ST_HUNT;
            w_NextCnt   = 4'd0;
            w_NextErr   = 4'd0;
        end else if (w_Advance) begin
            case (r_State)
                ST_HUNT: begin
                    if (w_AnyMatch) begin
                        w_NextOffset = w_FirstHit;
                        if (LOCK_CNT == 1) begin
                            w_NextState = ST_LOCKED;
                            w_NextCnt   = 4'd0;
                        end else begin
                            w_NextState = ST_VERIFY;
                            w_NextCnt   = 4'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (w_MatchAtOff) begin
                        if (({1'b0, r_Cnt} + 5'd1) == LOCK_THR) begin
                            w_NextState = ST_LOCKED;
                            w_NextCnt   = 4'd0;
                        end else begin
                            w_NextCnt = sat_inc4(r_Cnt);
                        end
                    end else if (w_AnyMatch) begin
                        w_NextOffset = w_FirstHit;
                        w_NextCnt    = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // a comma at the locked offset forgives earlier foreign commas
                    if (w_MatchAtOff) begin
                        w_NextErr = 4'd0;
                    end else if (w_AnyMatch) begin
                        if (({1'b0, r_ErrCnt} + 5'd1) == LOSS_THR) begin
                            w_NextState = ST_HUNT;
                            w_NextErr   = 4'd0;
                        end else begin
                            w_NextErr = sat_inc4(r_ErrCnt);
                        end
                    end
                end
                default: begin
                    w_NextState = ST_HUNT;
                end
            endcase
        end
    end

    // p1: aligned word uses the offset in force before this cycle's update
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Prev         <= '0;
            r_State        <= ST_HUNT;
            r_Offset       <= '0;
            r_Cnt          <= '0;
            r_ErrCnt       <= '0;
            r_AlignData_p1 <= '0;
            r_AlignVld_p1  <= 1'b0;
            r_ComDet_p1    <= 1'b0;
            r_Locked_p1    <= 1'b0;
        end else begin
            r_State       <= w_NextState;
            r_Offset      <= w_NextOffset;
            r_Cnt         <= w_NextCnt;
            r_ErrCnt      <= w_NextErr;
            r_Locked_p1   <= (w_NextState == ST_LOCKED);
            r_AlignVld_p1 <= i_RawVld;
            if (i_RawVld) begin
                r_Prev         <= i_RawData;
                r_AlignData_p1 <= w_Cand[r_Offset];
                r_ComDet_p1    <= w_MatchAtOff;
            end
        end
    end

`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] r_RealignCnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_RealignCnt <= '0;
        end else if ((r_State == ST_LOCKED) && (w_NextState == ST_HUNT) && (r_RealignCnt != 16'hFFFF)) begin
            r_RealignCnt <= r_RealignCnt + 16'd1;
        end
    end

    assign o_RealignCnt = r_RealignCnt;
`endif

    assign o_AlignData = r_AlignData_p1;
    assign o_AlignVld  = r_AlignVld_p1;
    assign o_ComDet    = r_ComDet_p1;
    assign o_Offset    = r_Offset;
    assign o_Locked    = r_Locked_p1;

endmodule
